// File: rtl/qtree_builder_if.sv
// -----------------------------------------------------------------------------
// qtree_builder_if
// Bundles the key-stream handshake, the status flags and the node-RAM write
// port of qtree_builder.
//   master : host/control side (drives start and the key stream)
//   slave  : the builder itself (drives ready, status and RAM writes)
// Signals:
//   start_i        load start / abort pulse
//   in_key_i       ascending key stream, with in_valid_i / in_last_i / in_ready_o
//   mm_ram_data_o  node word {l, m, r}
//   mm_ram_addr_o  node address within the target depth
//   mm_ram_write_o one-hot per-depth write strobe (bit 0 = root)
//   busy_o, done_o, err_o  status
// -----------------------------------------------------------------------------
interface qtree_builder_if #(
   parameter int KEY_WIDTH = 16,
   parameter int STAGE_CNT = 3
);
   localparam int ADDR_WIDTH     = 2 * (STAGE_CNT - 1);
   localparam int RAM_DATA_WIDTH = 3 * KEY_WIDTH;

   logic                      start_i;
   logic [KEY_WIDTH-1:0]      in_key_i;
   logic                      in_valid_i;
   logic                      in_last_i;
   logic                      in_ready_o;
   logic [RAM_DATA_WIDTH-1:0] mm_ram_data_o;
   logic [ADDR_WIDTH-1:0]     mm_ram_addr_o;
   logic [STAGE_CNT-1:0]      mm_ram_write_o;
   logic                      busy_o;
   logic                      done_o;
   logic                      err_o;

   modport master (
      output start_i, in_key_i, in_valid_i, in_last_i,
      input  in_ready_o, mm_ram_data_o, mm_ram_addr_o, mm_ram_write_o,
             busy_o, done_o, err_o
   );

   modport slave (
      input  start_i, in_key_i, in_valid_i, in_last_i,
      output in_ready_o, mm_ram_data_o, mm_ram_addr_o, mm_ram_write_o,
             busy_o, done_o, err_o
   );
endinterface

// File: rtl/qtree_builder.sv
// -----------------------------------------------------------------------------
// qtree_builder
// Turns an ascending key stream into the per-depth node words of a complete
// quadtree (3 keys per node) and writes them to the qstage RAMs. Short streams
// are padded with all-ones keys; a descending key sets a sticky error flag.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   bus    qtree_builder_if.slave (key stream, status, RAM write port)
// -----------------------------------------------------------------------------
module qtree_builder #(
   parameter int KEY_WIDTH = 16,
   parameter int STAGE_CNT = 3
) (
   input  logic            clk_i,
   input  logic            rst_i,
   qtree_builder_if.slave  bus
);
   localparam int ADDR_WIDTH     = 2 * (STAGE_CNT - 1);
   localparam int RAM_DATA_WIDTH = 3 * KEY_WIDTH;
   localparam int KW             = 2 * STAGE_CNT;
   localparam int TW             = (STAGE_CNT > 2) ? $clog2(STAGE_CNT) : 1;
   // 4**STAGE_CNT - 1 is exactly all ones in 2*STAGE_CNT bits
   localparam logic [KW-1:0] CAP = '1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_DONE} state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic [KW-1:0]             r_k;
   logic [KEY_WIDTH-1:0]      r_prev;
   logic                      r_err;
   logic                      r_done;
   logic [STAGE_CNT-1:0]      r_write;
   logic [ADDR_WIDTH-1:0]     r_addr;
   logic [RAM_DATA_WIDTH-1:0] r_data;

   logic                      w_restart;
   logic                      w_fire;
   logic [KW-1:0]             w_j;
   logic                      w_last_idx;
   logic [KEY_WIDTH-1:0]      w_key;
   logic [TW-1:0]             w_t;
   logic [TW-1:0]             w_depth;
   logic [1:0]                w_slot;
   logic [KW-1:0]             w_shift;
   logic [ADDR_WIDTH-1:0]     w_addr;
   logic [STAGE_CNT-1:0]      w_strobe;
   logic [KEY_WIDTH-1:0]      w_l_all [STAGE_CNT];
   logic [KEY_WIDTH-1:0]      w_m_all [STAGE_CNT];
   logic [KEY_WIDTH-1:0]      w_l_sel;
   logic [KEY_WIDTH-1:0]      w_m_sel;

   // start aborts LOAD/PAD and starts from IDLE, but is ignored in DONE
   assign w_restart  = bus.start_i && (r_state != S_DONE);
   // a start in the same cycle wins over the key; that key is dropped
   assign w_fire     = !w_restart &&
                       (((r_state == S_LOAD) && bus.in_valid_i) || (r_state == S_PAD));
   assign w_j        = r_k + KW'(1);
   assign w_last_idx = (w_j == CAP);
   assign w_key      = (r_state == S_PAD) ? {KEY_WIDTH{1'b1}} : bus.in_key_i;

   // t = number of trailing zero base-4 digits of j (j is never 0 on a fire)
   always_comb begin
      w_t = '0;
      for (int d = STAGE_CNT - 1; d >= 0; d--) begin
         if (w_j[2*d +: 2] != 2'b00) begin
            w_t = TW'(d);
         end
      end
   end

   assign w_depth  = TW'(STAGE_CNT - 1) - w_t;
   assign w_slot   = w_j[2*int'(w_t) +: 2];
   assign w_shift  = w_j >> (2 * (int'(w_t) + 1));
   assign w_addr   = w_shift[ADDR_WIDTH-1:0];
   assign w_strobe = {{(STAGE_CNT-1){1'b0}}, 1'b1} << w_depth;

   // per-depth l/m holding registers
   for (genvar gi = 0; gi < STAGE_CNT; gi++) begin : g_hold
      logic [KEY_WIDTH-1:0] r_l_hold;
      logic [KEY_WIDTH-1:0] r_m_hold;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_l_hold <= '0;
            r_m_hold <= '0;
         end else if (w_restart) begin
            r_l_hold <= '0;
            r_m_hold <= '0;
         end else if (w_fire && (w_depth == TW'(gi))) begin
            if (w_slot == 2'd1) r_l_hold <= w_key;
            if (w_slot == 2'd2) r_m_hold <= w_key;
         end
      end

      assign w_l_all[gi] = r_l_hold;
      assign w_m_all[gi] = r_m_hold;
   end

   assign w_l_sel = w_l_all[w_depth];
   assign w_m_sel = w_m_all[w_depth];

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // FSM next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (bus.start_i) w_state_next = S_LOAD;
         S_LOAD: begin
            if (w_restart)                   w_state_next = S_LOAD;
            else if (w_fire && w_last_idx)   w_state_next = S_DONE;
            else if (w_fire && bus.in_last_i) w_state_next = S_PAD;
         end
         S_PAD: begin
            if (w_restart)                 w_state_next = S_LOAD;
            else if (w_fire && w_last_idx) w_state_next = S_DONE;
         end
         S_DONE: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // key counter, order check and registered RAM write port
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_k     <= '0;
         r_prev  <= '0;
         r_err   <= 1'b0;
         r_done  <= 1'b0;
         r_write <= '0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_write <= '0;
         r_done  <= 1'b0;
         if (w_restart) begin
            r_k    <= '0;
            r_prev <= '0;
            r_err  <= 1'b0;
         end else if (w_fire) begin
            r_k <= w_j;
            if (r_state == S_LOAD) begin
               r_prev <= w_key;
               // prev starts at 0, so the first key can never flag
               if (w_key < r_prev) r_err <= 1'b1;
            end
            if (w_slot == 2'd3) begin
               r_write <= w_strobe;
               r_addr  <= w_addr;
               r_data  <= {w_l_sel, w_m_sel, w_key};
            end
            if (w_last_idx) r_done <= 1'b1;
         end
      end
   end

   assign bus.in_ready_o     = (r_state == S_LOAD);
   assign bus.busy_o         = (r_state == S_LOAD) || (r_state == S_PAD);
   assign bus.done_o         = r_done;
   assign bus.err_o          = r_err;
   assign bus.mm_ram_write_o = r_write;
   assign bus.mm_ram_addr_o  = r_addr;
   assign bus.mm_ram_data_o  = r_data;
endmodule

// File: tb/tb_qtree_builder.sv
module tb_qtree_builder;
   localparam int KW = 16;
   localparam int SC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   qtree_builder_if #(.KEY_WIDTH(KW), .STAGE_CNT(SC)) bus ();
   qtree_builder #(.KEY_WIDTH(KW), .STAGE_CNT(SC)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] key;
      logic        last;
      logic [1:0]  wr;
      logic [1:0]  addr;
      logic [47:0] data;
      logic        done;
      logic        err;
   } vec_t;

   vec_t tbl [15];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
   endtask

   // keys 1..15, writes hand-computed for the 15-key quadtree
   task automatic fill_table();
      for (int i = 0; i < 15; i++) begin
         tbl[i].key  = 16'(i + 1);
         tbl[i].last = (i == 14);
         tbl[i].wr   = 2'b00;
         tbl[i].addr = 2'd0;
         tbl[i].data = '0;
         tbl[i].done = 1'b0;
         tbl[i].err  = 1'b0;
      end
      tbl[2].wr  = 2'b10; tbl[2].addr  = 2'd0; tbl[2].data  = {16'd1,  16'd2,  16'd3};
      tbl[6].wr  = 2'b10; tbl[6].addr  = 2'd1; tbl[6].data  = {16'd5,  16'd6,  16'd7};
      tbl[10].wr = 2'b10; tbl[10].addr = 2'd2; tbl[10].data = {16'd9,  16'd10, 16'd11};
      tbl[11].wr = 2'b01; tbl[11].addr = 2'd0; tbl[11].data = {16'd4,  16'd8,  16'd12};
      tbl[14].wr = 2'b10; tbl[14].addr = 2'd3; tbl[14].data = {16'd13, 16'd14, 16'd15};
      tbl[14].done = 1'b1;
   endtask

   task automatic run_table(input string tag, input bit gaps);
      for (int i = 0; i < 15; i++) begin
         bus.in_key_i   = tbl[i].key;
         bus.in_last_i  = tbl[i].last;
         bus.in_valid_i = 1'b1;
         tick();
         bus.in_valid_i = 1'b0;
         bus.in_last_i  = 1'b0;
         $display("%s: key=%0d wr=%b addr=%0d data=%h done=%b err=%b", tag, tbl[i].key,
                  bus.mm_ram_write_o, bus.mm_ram_addr_o, bus.mm_ram_data_o, bus.done_o, bus.err_o);
         chk({tag, "_wr"}, 64'(bus.mm_ram_write_o), 64'(tbl[i].wr));
         if (tbl[i].wr != 2'b00) begin
            chk({tag, "_addr"}, 64'(bus.mm_ram_addr_o), 64'(tbl[i].addr));
            chk({tag, "_data"}, 64'(bus.mm_ram_data_o), 64'(tbl[i].data));
         end
         chk({tag, "_done"}, 64'(bus.done_o), 64'(tbl[i].done));
         chk({tag, "_err"}, 64'(bus.err_o), 64'(tbl[i].err));
         if (gaps && i < 14) begin
            tick();
            chk({tag, "_gap_wr"}, 64'(bus.mm_ram_write_o), 64'd0);
         end
      end
   endtask

   task automatic send_key(input logic [15:0] key, input logic last);
      bus.in_key_i   = key;
      bus.in_last_i  = last;
      bus.in_valid_i = 1'b1;
      tick();
      bus.in_valid_i = 1'b0;
      bus.in_last_i  = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_wr"},    64'(bus.mm_ram_write_o), 64'd0);
      chk({tag, "_addr"},  64'(bus.mm_ram_addr_o),  64'd0);
      chk({tag, "_data"},  64'(bus.mm_ram_data_o),  64'd0);
      chk({tag, "_busy"},  64'(bus.busy_o),         64'd0);
      chk({tag, "_done"},  64'(bus.done_o),         64'd0);
      chk({tag, "_err"},   64'(bus.err_o),          64'd0);
      chk({tag, "_ready"}, 64'(bus.in_ready_o),     64'd0);
   endtask

   initial begin
      bus.start_i    = 1'b0;
      bus.in_key_i   = '0;
      bus.in_valid_i = 1'b0;
      bus.in_last_i  = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      $display("reset: outputs checked");
      rst = 1'b0;
      tick();

      // full stream
      fill_table();
      pulse_start();
      chk("full_ready", 64'(bus.in_ready_o), 64'd1);
      chk("full_busy",  64'(bus.busy_o),     64'd1);
      run_table("full", 1'b0);
      tick();
      chk("full_done_pulse", 64'(bus.done_o), 64'd0);
      chk("full_idle_busy",  64'(bus.busy_o), 64'd0);

      // padding
      pulse_start();
      send_key(16'd10, 1'b0);
      chk("pad_k10_wr", 64'(bus.mm_ram_write_o), 64'd0);
      send_key(16'd20, 1'b0);
      send_key(16'd30, 1'b1);
      $display("pad: key=30 wr=%b data=%h", bus.mm_ram_write_o, bus.mm_ram_data_o);
      chk("pad_k30_wr",   64'(bus.mm_ram_write_o), 64'b10);
      chk("pad_k30_addr", 64'(bus.mm_ram_addr_o),  64'd0);
      chk("pad_k30_data", 64'(bus.mm_ram_data_o),  64'({16'd10, 16'd20, 16'd30}));
      chk("pad_busy",     64'(bus.busy_o),         64'd1);
      for (int j = 4; j <= 15; j++) begin
         logic [1:0] ewr;
         logic [1:0] eaddr;
         chk("pad_ready", 64'(bus.in_ready_o), 64'd0);
         tick();
         ewr   = 2'b00;
         eaddr = 2'd0;
         if (j == 7)  begin ewr = 2'b10; eaddr = 2'd1; end
         if (j == 11) begin ewr = 2'b10; eaddr = 2'd2; end
         if (j == 12) begin ewr = 2'b01; eaddr = 2'd0; end
         if (j == 15) begin ewr = 2'b10; eaddr = 2'd3; end
         $display("pad: j=%0d wr=%b addr=%0d data=%h done=%b", j, bus.mm_ram_write_o,
                  bus.mm_ram_addr_o, bus.mm_ram_data_o, bus.done_o);
         chk("pad_wr", 64'(bus.mm_ram_write_o), 64'(ewr));
         if (ewr != 2'b00) begin
            chk("pad_addr", 64'(bus.mm_ram_addr_o), 64'(eaddr));
            chk("pad_data", 64'(bus.mm_ram_data_o), 64'h0000_FFFF_FFFF_FFFF);
         end
         chk("pad_done", 64'(bus.done_o), 64'(j == 15));
      end
      tick();

      // valid toggling every other cycle
      fill_table();
      pulse_start();
      run_table("gaps", 1'b1);
      tick();

      // order error: 1,2,5,4,5..15
      fill_table();
      tbl[2].key  = 16'd5;
      tbl[2].data = {16'd1, 16'd2, 16'd5};
      tbl[3].key  = 16'd4;
      for (int i = 3; i < 15; i++) tbl[i].err = 1'b1;
      pulse_start();
      run_table("order", 1'b0);
      tick();
      chk("order_err_sticky", 64'(bus.err_o), 64'd1);

      // restart after 6 keys
      fill_table();
      pulse_start();
      for (int i = 1; i <= 6; i++) send_key(16'(i), 1'b0);
      pulse_start();
      chk("restart_busy", 64'(bus.busy_o), 64'd1);
      chk("restart_err",  64'(bus.err_o),  64'd0);
      run_table("restart", 1'b0);
      tick();

      // async reset mid-PAD
      pulse_start();
      send_key(16'd10, 1'b0);
      send_key(16'd20, 1'b0);
      send_key(16'd30, 1'b1);
      tick();
      tick();
      tick();
      chk("areset_pre_busy", 64'(bus.busy_o), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("areset");
      $display("areset: outputs checked mid-cycle");
      #2;
      rst = 1'b0;
      tick();
      chk("areset_idle_busy", 64'(bus.busy_o), 64'd0);
      fill_table();
      pulse_start();
      run_table("after_reset", 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
